// File: rtl/store_buffer_fifo.sv
// Store buffer: circular FIFO of pending stores with coalescing, load forwarding,
// threshold-triggered draining and a flush mode that drains until empty.
module store_buffer_fifo #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NLINES       = 4,
    parameter int DRAIN_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_WIDTH-1:0]     st_addr,
    input  logic [DATA_WIDTH-1:0]     st_data,
    input  logic                      ld_valid,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    output logic                      ld_hit,
    output logic [DATA_WIDTH-1:0]     ld_data,
    output logic                      drain_valid,
    input  logic                      drain_ready,
    output logic [ADDR_WIDTH-1:0]     drain_addr,
    output logic [DATA_WIDTH-1:0]     drain_data,
    input  logic                      flush,
    output logic                      flushing,
    output logic [$clog2(NLINES):0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(NLINES);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t FULL_CNT   = cnt_t'(NLINES);
    localparam cnt_t THRESH_CNT = cnt_t'(DRAIN_THRESH);

    typedef enum logic {
        FL_IDLE,
        FL_ACTIVE
    } fl_state_e;

    logic [NLINES-1:0]     valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q [NLINES];
    logic [ADDR_WIDTH-1:0] addr_d [NLINES];
    logic [DATA_WIDTH-1:0] data_q [NLINES];
    logic [DATA_WIDTH-1:0] data_d [NLINES];
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    cnt_t                  count_q, count_d;
    fl_state_e             fl_state_q, fl_state_d;

    logic drain_fire;
    logic st_match;
    logic st_fire;
    ptr_t match_idx;

    // Status, handshakes, store match and load forwarding all derive from
    // register state only, so a same-cycle store is never forwarded.
    always_comb begin
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        count       = count_q;
        flushing    = (fl_state_q == FL_ACTIVE);
        drain_valid = !empty && ((count_q >= THRESH_CNT) || flushing);
        drain_fire  = drain_valid && drain_ready;
        drain_addr  = empty ? '0 : addr_q[head_q];
        drain_data  = empty ? '0 : data_q[head_q];

        st_match  = 1'b0;
        match_idx = '0;
        ld_hit    = 1'b0;
        ld_data   = '0;
        for (int unsigned i = 0; i < NLINES; i++) begin
            // The head leaving this cycle cannot absorb a coalescing write.
            if (st_valid && valid_q[i] && (addr_q[i] == st_addr) &&
                !(drain_fire && (ptr_t'(i) == head_q))) begin
                st_match  = 1'b1;
                match_idx = ptr_t'(i);
            end
            if (ld_valid && valid_q[i] && (addr_q[i] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[i];
            end
        end

        st_ready = st_match || !full || drain_fire;
        st_fire  = st_valid && st_ready;
    end

    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fl_state_d = fl_state_q;

        // Drain clears first so a store into the slot it frees (full case) wins.
        if (drain_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ptr_t'(1);
        end

        if (st_fire) begin
            if (st_match) begin
                data_d[match_idx] = st_data;
            end else begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = st_addr;
                data_d[tail_q]  = st_data;
                tail_d          = tail_q + ptr_t'(1);
            end
        end

        if (st_fire && !st_match && !drain_fire) begin
            count_d = count_q + cnt_t'(1);
        end else if (drain_fire && !(st_fire && !st_match)) begin
            count_d = count_q - cnt_t'(1);
        end

        case (fl_state_q)
            FL_IDLE: begin
                if (flush && !empty) begin
                    fl_state_d = FL_ACTIVE;
                end
            end
            FL_ACTIVE: begin
                if (empty) begin
                    fl_state_d = FL_IDLE;
                end
            end
            default: fl_state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fl_state_q <= FL_IDLE;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fl_state_q <= fl_state_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Directed bench for store_buffer_fifo: drain threshold, coalescing, forwarding,
// flush, full-with-drain store and asynchronous reset mid-flush.
module tb_store_buffer_fifo;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drain_valid;
    logic        drain_ready;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic        flush;
    logic        flushing;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    store_buffer_fifo #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NLINES      (4),
        .DRAIN_THRESH(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .drain_valid(drain_valid),
        .drain_ready(drain_ready),
        .drain_addr (drain_addr),
        .drain_data (drain_data),
        .flush      (flush),
        .flushing   (flushing),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        st_valid    = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        drain_ready = 1'b0;
        flush       = 1'b0;
        #1;
        check("rst_count",  32'(count),       32'd0);
        check("rst_empty",  32'(empty),       32'd1);
        check("rst_full",   32'(full),        32'd0);
        check("rst_dvalid", 32'(drain_valid), 32'd0);
        check("rst_stready",32'(st_ready),    32'd1);
        check("rst_flush",  32'(flushing),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Threshold drain: two stores, head drains, one remains below threshold.
        drain_ready = 1'b1;
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h1;
        #1 check("st1_ready", 32'(st_ready), 32'd1);
        tick;
        check("st1_count",  32'(count),       32'd1);
        check("st1_dvalid", 32'(drain_valid), 32'd0);
        st_addr = 32'h20; st_data = 32'h2;
        tick;
        st_valid = 1'b0;
        check("st2_count",  32'(count),       32'd2);
        check("st2_dvalid", 32'(drain_valid), 32'd1);
        check("st2_daddr",  drain_addr,       32'h10);
        check("st2_ddata",  drain_data,       32'h1);
        tick;
        check("dr1_count",  32'(count),       32'd1);
        check("dr1_dvalid", 32'(drain_valid), 32'd0);
        check("dr1_daddr",  drain_addr,       32'h20);

        // Flush with a single entry.
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("fl_flushing", 32'(flushing),    32'd1);
        check("fl_dvalid",   32'(drain_valid), 32'd1);
        check("fl_daddr",    drain_addr,       32'h20);
        check("fl_ddata",    drain_data,       32'h2);
        tick;
        check("fl_empty",    32'(empty),       32'd1);
        check("fl_count",    32'(count),       32'd0);
        tick;
        check("fl_done",     32'(flushing),    32'd0);

        // Fill to full with drain stalled, then reject new address and coalesce.
        drain_ready = 1'b0;
        st_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            st_addr = 32'(k * 16);
            st_data = 32'(k);
            tick;
        end
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd4);
        st_addr = 32'h50; st_data = 32'h55;
        #1 check("full_reject", 32'(st_ready), 32'd0);
        tick;
        check("reject_count", 32'(count), 32'd4);
        ld_valid = 1'b1; ld_addr = 32'h50;
        #1 check("reject_nohit", 32'(ld_hit), 32'd0);
        st_addr = 32'h20; st_data = 32'hAA;
        #1 check("coal_ready", 32'(st_ready), 32'd1);
        tick;
        st_valid = 1'b0;
        check("coal_count", 32'(count), 32'd4);
        ld_addr = 32'h20;
        #1;
        check("coal_ldhit",  32'(ld_hit), 32'd1);
        check("coal_lddata", ld_data,     32'hAA);

        // Full buffer: store accepted alongside a drain, count holds at 4.
        drain_ready = 1'b1;
        st_valid = 1'b1; st_addr = 32'h60; st_data = 32'h6;
        #1;
        check("fd_ready", 32'(st_ready), 32'd1);
        check("fd_daddr", drain_addr,    32'h10);
        tick;
        st_valid = 1'b0;
        check("fd_count", 32'(count),   32'd4);
        check("fd_full",  32'(full),    32'd1);
        check("fd_daddr2", drain_addr,  32'h20);
        check("fd_ddata2", drain_data,  32'hAA);
        check("head_fwd_hit",  32'(ld_hit), 32'd1);
        check("head_fwd_data", ld_data,     32'hAA);
        tick;
        check("fd_daddr3", drain_addr, 32'h30);
        check("fd_ddata3", drain_data, 32'h3);
        tick;
        check("fd_daddr4", drain_addr, 32'h40);
        tick;
        check("fd_tail_dvalid", 32'(drain_valid), 32'd0);
        check("fd_tail_count",  32'(count),       32'd1);
        check("fd_tail_daddr",  drain_addr,       32'h60);
        check("fd_tail_ddata",  drain_data,       32'h6);

        // Forwarding only from register state.
        drain_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'hBB; st_data = 32'h1234;
        ld_addr = 32'hBB;
        #1 check("fwd_same_cycle", 32'(ld_hit), 32'd0);
        tick;
        st_valid = 1'b0;
        check("fwd_hit",   32'(ld_hit), 32'd1);
        check("fwd_data",  ld_data,     32'h1234);
        check("fwd_count", 32'(count),  32'd2);
        ld_addr = 32'hCC;
        #1;
        check("miss_hit",  32'(ld_hit), 32'd0);
        check("miss_data", ld_data,     32'h0);

        // Asynchronous reset in the middle of a stalled flush with three entries.
        st_valid = 1'b1; st_addr = 32'hDD; st_data = 32'h77;
        tick;
        st_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("pre_rst_flushing", 32'(flushing),    32'd1);
        check("pre_rst_dvalid",   32'(drain_valid), 32'd1);
        ld_addr = 32'hBB;
        #2 reset = 1'b1;
        #1;
        check("arst_count",   32'(count),       32'd0);
        check("arst_empty",   32'(empty),       32'd1);
        check("arst_full",    32'(full),        32'd0);
        check("arst_flush",   32'(flushing),    32'd0);
        check("arst_dvalid",  32'(drain_valid), 32'd0);
        check("arst_ldhit",   32'(ld_hit),      32'd0);
        check("arst_stready", 32'(st_ready),    32'd1);
        check("arst_daddr",   drain_addr,       32'h0);
        @(negedge clk);
        reset = 1'b0;
        drain_ready = 1'b1;
        tick;
        tick;
        check("post_rst_dvalid", 32'(drain_valid), 32'd0);
        check("post_rst_empty",  32'(empty),       32'd1);
        check("post_rst_ldhit",  32'(ld_hit),      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
